// File: rtl/modinv_helper_reduce_scheduler.sv
// Reduction-phase sequencer for the modular invertor: runs calc/update helper pairs for NUM_ITERS iterations.
// Optional MODINV_REDUCE_EARLY_EXIT_EN: stop as soon as k is exhausted (run length then depends on k).
module modinv_helper_reduce_scheduler #(
    parameter int NUM_ITERS = 512,
    parameter int K_BITS    = 10,
    parameter int ITER_BITS = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ena,
    output logic                 rdy,
    input  logic [K_BITS-1:0]    k_in,
    input  logic                 s_lsb,
    output logic                 calc_ena,
    input  logic                 calc_rdy,
    output logic                 upd_ena,
    input  logic                 upd_rdy,
    output logic                 s_is_odd,
    output logic                 k_is_nul,
    output logic [2:0]           state_dbg
);

    // Handshake: ena is taken only in IDLE (rdy=1); helper pulses last one cycle,
    // and a helper's rdy is ignored on the first wait cycle because it drops a cycle late.

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        CALC_GO   = 3'd1,
        CALC_WAIT = 3'd2,
        UPD_GO    = 3'd3,
        UPD_WAIT  = 3'd4
    } state_t;

    localparam logic [ITER_BITS-1:0] LAST_ITER = ITER_BITS'(NUM_ITERS - 1);

    state_t                state;
    logic [K_BITS-1:0]     k_cnt;
    logic [ITER_BITS-1:0]  iter_cnt;
    logic                  first_wait;
    logic [K_BITS-1:0]     k_dec;
    logic                  run_done;

    assign state_dbg = state;

    always_comb begin
        k_dec    = (k_cnt != '0) ? (k_cnt - K_BITS'(1)) : '0;
        run_done = (iter_cnt == LAST_ITER);
`ifdef MODINV_REDUCE_EARLY_EXIT_EN
        if (k_dec == '0) run_done = 1'b1;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            rdy        <= 1'b1;
            calc_ena   <= 1'b0;
            upd_ena    <= 1'b0;
            s_is_odd   <= 1'b0;
            k_is_nul   <= 1'b0;
            k_cnt      <= '0;
            iter_cnt   <= '0;
            first_wait <= 1'b0;
        end else begin
            calc_ena <= 1'b0;
            upd_ena  <= 1'b0;
            case (state)
                IDLE: begin
                    rdy <= 1'b1;
`ifdef MODINV_REDUCE_EARLY_EXIT_EN
                    if (ena && (k_in != '0)) begin
`else
                    if (ena) begin
`endif
                        k_cnt    <= k_in;
                        iter_cnt <= '0;
                        rdy      <= 1'b0;
                        calc_ena <= 1'b1;
                        state    <= CALC_GO;
                    end
                end
                CALC_GO: begin
                    // Parity and k status are frozen here for the rest of the iteration.
                    s_is_odd   <= s_lsb;
                    k_is_nul   <= (k_cnt == '0);
                    first_wait <= 1'b1;
                    state      <= CALC_WAIT;
                end
                CALC_WAIT: begin
                    first_wait <= 1'b0;
                    if (!first_wait && calc_rdy) begin
                        upd_ena <= 1'b1;
                        state   <= UPD_GO;
                    end
                end
                UPD_GO: begin
                    first_wait <= 1'b1;
                    state      <= UPD_WAIT;
                end
                UPD_WAIT: begin
                    first_wait <= 1'b0;
                    if (!first_wait && upd_rdy) begin
                        iter_cnt <= iter_cnt + ITER_BITS'(1);
                        k_cnt    <= k_dec;
                        if (run_done) begin
                            rdy   <= 1'b1;
                            state <= IDLE;
                        end else begin
                            calc_ena <= 1'b1;
                            state    <= CALC_GO;
                        end
                    end
                end
                default: begin
                    rdy   <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_modinv_helper_reduce_scheduler.sv
// Scoreboarded bench for modinv_helper_reduce_scheduler with NUM_ITERS=4 and 3-cycle helpers.
// Honours MODINV_REDUCE_EARLY_EXIT_EN when computing expected iteration counts.
module tb_modinv_helper_reduce_scheduler;

    localparam int N  = 4;
    localparam int KB = 4;
    localparam int IB = 3;
    localparam int LC = 3;
    localparam int LU = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          ena = 1'b0;
    logic          rdy;
    logic [KB-1:0] k_in = '0;
    logic          s_lsb = 1'b0;
    logic          calc_ena, calc_rdy, upd_ena, upd_rdy;
    logic          s_is_odd, k_is_nul;
    logic [2:0]    state_dbg;

    int checks = 0;
    int failures = 0;

    logic [1:0] exp_q[$];
    logic [3:0] pat = 4'b0000;
    int         calc_seen = 0;
    int         upd_seen = 0;

    modinv_helper_reduce_scheduler #(.NUM_ITERS(N), .K_BITS(KB), .ITER_BITS(IB)) dut (
        .clk(clk), .rst(rst), .ena(ena), .rdy(rdy), .k_in(k_in), .s_lsb(s_lsb),
        .calc_ena(calc_ena), .calc_rdy(calc_rdy), .upd_ena(upd_ena), .upd_rdy(upd_rdy),
        .s_is_odd(s_is_odd), .k_is_nul(k_is_nul), .state_dbg(state_dbg)
    );

    // Clock / reset
    always #5 clk = ~clk;

    // Helper models: rdy stays high one cycle after ena, then low until the latency elapses.
    logic c_pend, u_pend;
    int   c_cnt, u_cnt;
    assign calc_rdy = (c_cnt == 0);
    assign upd_rdy  = (u_cnt == 0);
    always @(posedge clk) begin
        if (rst) begin
            c_pend <= 1'b0; c_cnt <= 0; u_pend <= 1'b0; u_cnt <= 0;
        end else begin
            if (calc_ena) c_pend <= 1'b1;
            else if (c_pend) begin c_pend <= 1'b0; c_cnt <= LC - 2; end
            else if (c_cnt != 0) c_cnt <= c_cnt - 1;
            if (upd_ena) u_pend <= 1'b1;
            else if (u_pend) begin u_pend <= 1'b0; u_cnt <= LU - 2; end
            else if (u_cnt != 0) u_cnt <= u_cnt - 1;
        end
    end

    // s_lsb: pattern value during CALC_GO, random noise at all other times.
    int pat_idx = 0;
    always @(negedge clk) begin
        if (rdy) pat_idx = 0;
        if (calc_ena) begin
            s_lsb = pat[pat_idx % 4];
            pat_idx = pat_idx + 1;
        end else begin
            s_lsb = 1'($urandom_range(0, 1));
        end
    end

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Monitor: pulse rules, hold rule, and scoreboard pop on each upd_ena pulse.
    logic       last_was_calc = 1'b0;
    logic [1:0] prev_flags = 2'b00;
    logic       prev_calc = 1'b0;
    always @(negedge clk) begin
        if (rst) begin
            last_was_calc = 1'b0;
            prev_flags = 2'b00;
            prev_calc = 1'b0;
        end else begin
            if (calc_ena && upd_ena) check("pulse_exclusive", 1, 0);
            if (({k_is_nul, s_is_odd} != prev_flags) && !prev_calc)
                check("flags_change_outside_calc_go", 1, 0);
            if (calc_ena) begin
                check("calc_after_upd", int'(last_was_calc), 0);
                last_was_calc = 1'b1;
                calc_seen++;
            end
            if (upd_ena) begin
                check("upd_after_calc", int'(last_was_calc), 1);
                last_was_calc = 1'b0;
                upd_seen++;
                if (exp_q.size() == 0) begin
                    check("unexpected_upd_pulse", 1, 0);
                end else begin
                    logic [1:0] e;
                    e = exp_q.pop_front();
                    check("k_is_nul_at_upd", int'(k_is_nul), int'(e[1]));
                    check("s_is_odd_at_upd", int'(s_is_odd), int'(e[0]));
                end
            end
            prev_flags = {k_is_nul, s_is_odd};
            prev_calc = calc_ena;
        end
    end

    function automatic int exp_iters(input int k);
`ifdef MODINV_REDUCE_EARLY_EXIT_EN
        return (k < N) ? k : N;
`else
        return N;
`endif
    endfunction

    task automatic wait_idle();
        int guard = 0;
        while (!rdy && guard < 200) begin @(negedge clk); guard++; end
        if (!rdy) check("idle_timeout", 0, 1);
    endtask

    // Driver: one full run with expected per-iteration flags queued up front.
    task automatic do_run(input int k, input logic [3:0] p, input bit disturb, input string tag);
        int n, cyc, c0, u0;
        n = exp_iters(k);
        wait_idle();
        pat = p;
        for (int i = 0; i < n; i++) exp_q.push_back({(i >= k) ? 1'b1 : 1'b0, p[i]});
        c0 = calc_seen; u0 = upd_seen;
        ena = 1'b1; k_in = KB'(k);
        cyc = 0;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            ena = 1'b0;
            if (disturb && (t == 5 || t == 17)) begin
                ena = 1'b1;
                k_in = KB'($urandom_range(0, 15));
            end
            if (rdy) break;
            cyc++;
        end
        ena = 1'b0;
        check({tag, "_busy_cycles"}, cyc, n * (LC + LU + 2));
        check({tag, "_calc_pulses"}, calc_seen - c0, n);
        check({tag, "_upd_pulses"}, upd_seen - u0, n);
        check({tag, "_queue_empty"}, exp_q.size(), 0);
    endtask

    initial begin
        int seen;
        // Reset held three cycles with ena high.
        rst = 1'b1; ena = 1'b1; k_in = 4'd2;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_rdy", int'(rdy), 1);
            check("rst_calc_ena", int'(calc_ena), 0);
            check("rst_upd_ena", int'(upd_ena), 0);
        end
        check("rst_s_is_odd", int'(s_is_odd), 0);
        check("rst_k_is_nul", int'(k_is_nul), 0);
        rst = 1'b0; ena = 1'b0;
        @(negedge clk);
        check("post_rst_rdy", int'(rdy), 1);

        do_run(2, 4'b1101, 1'b0, "k2");
        do_run(0, 4'b0110, 1'b0, "k0");
        do_run(7, 4'b1011, 1'b1, "k7_disturb");
        do_run(1, 4'b0101, 1'b0, "k1");
        do_run(2, 4'b0010, 1'b1, "k2_disturb");

        // Reset in UPD_WAIT of iteration 2, then a fresh run.
        wait_idle();
        pat = 4'b1111;
        for (int i = 0; i < 3; i++) exp_q.push_back({1'b0, 1'b1});
        ena = 1'b1; k_in = 4'd3;
        @(negedge clk);
        ena = 1'b0;
        seen = 0;
        for (int t = 0; t < 200 && seen < 3; t++) begin
            if (upd_ena) seen++;
            if (seen < 3) @(negedge clk);
        end
        check("abort_reached_iter2", seen, 3);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_rdy", int'(rdy), 1);
        check("abort_calc_ena", int'(calc_ena), 0);
        check("abort_upd_ena", int'(upd_ena), 0);
        check("abort_state", int'(state_dbg), 0);
        check("abort_queue_drained", exp_q.size(), 0);
        exp_q.delete();
        seen = calc_seen;
        repeat (10) @(negedge clk);
        check("abort_no_reissue", calc_seen - seen, 0);
        do_run(2, 4'b1001, 1'b0, "after_abort");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        failures++;
        $display("FAIL global_timeout actual=timeout required=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

endmodule
